// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler
// Latches floor calls for a 4-floor car, picks the next target with a SCAN
// (keep-direction) policy, commands car movement and owns door dwell timing.
// All outputs are registered. The optional MOVE watchdog is compiled in when
// the macro ELEV_SCHED_WDOG_EN is defined; without it fault is tied low and
// MOVE waits for arrival indefinitely.
//
// Handshake with the car datapath: move_req stays high for the whole MOVE
// state while target_floor is held (or retargeted to a nearer call on the
// way); the car answers with car_arrived, which is accepted only together
// with car_floor == target_floor and only while moving.
module elevator_call_scheduler #(
  parameter int DWELL_CYCLES = 8,
  parameter int WDOG_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] call_req,
  input  logic [1:0] car_floor,
  input  logic       car_arrived,
  input  logic       sw_open,
  input  logic       sw_close,
  output logic [1:0] target_floor,
  output logic       move_req,
  output logic       door_open,
  output logic       dir_up,
  output logic [3:0] pending,
  output logic       fault,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_MOVE, S_DOOR} state_t;

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_target;
  logic            r_dir_up;
  logic [3:0]      r_pending;
  logic            r_move_req;
  logic            r_door_open;
  logic [DW-1:0]   r_dwell;

  logic [3:0]      w_calls;
  logic [3:0]      w_floor_oh;
  logic [3:0]      w_target_oh;
  logic            w_here;
  logic            w_arrive;
  logic            w_reload;
  logic            w_expire;
  logic            w_wdog_trip;
  logic            w_above_vld, w_below_vld, w_rt_vld, w_sel_vld;
  logic [1:0]      w_above, w_below, w_rt, w_sel_floor;
  logic            w_sel_dir;
  logic [1:0]      w_target_nxt;
  logic            w_dir_nxt;
  logic [3:0]      w_pending_nxt;
  logic [DW-1:0]   w_dwell_nxt;

`ifdef ELEV_SCHED_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
  logic [WW-1:0] r_wdog;
  logic          r_fault;

  // Watchdog: counts MOVE cycles, restarts on state entry and on retarget; fault is sticky
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog  <= '0;
      r_fault <= 1'b0;
    end else begin
      if (r_state == S_MOVE && w_state_nxt == S_MOVE && !(w_rt_vld && !car_arrived))
        r_wdog <= r_wdog + 1'b1;
      else
        r_wdog <= '0;
      if (w_wdog_trip) r_fault <= 1'b1;
    end
  end

  assign w_wdog_trip = (r_state == S_MOVE) && !w_arrive && (r_wdog == WDOG_LAST);
  assign w_calls     = r_fault ? 4'b0000 : call_req;
  assign fault       = r_fault;
`else
  assign w_wdog_trip = 1'b0;
  assign w_calls     = call_req;
  assign fault       = 1'b0;
`endif

  assign w_floor_oh  = 4'b0001 << car_floor;
  assign w_target_oh = 4'b0001 << r_target;
  assign w_here      = r_pending[car_floor];
  assign w_arrive    = car_arrived && (car_floor == r_target);
  assign w_reload    = sw_open || call_req[car_floor];
  assign w_expire    = !w_reload && (sw_close || (r_dwell == '0));

  // Nearest pending floor above and below the car, plus nearest new call on the way
  always_comb begin
    w_above_vld = 1'b0;
    w_above     = 2'd0;
    w_below_vld = 1'b0;
    w_below     = 2'd0;
    w_rt_vld    = 1'b0;
    w_rt        = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_pending[i] && i > int'(car_floor)) begin
        w_above_vld = 1'b1;
        w_above     = i[1:0];
      end
      if (r_dir_up && w_calls[i] && i > int'(car_floor) && i < int'(r_target)) begin
        w_rt_vld = 1'b1;
        w_rt     = i[1:0];
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (r_pending[i] && i < int'(car_floor)) begin
        w_below_vld = 1'b1;
        w_below     = i[1:0];
      end
      if (!r_dir_up && w_calls[i] && i < int'(car_floor) && i > int'(r_target)) begin
        w_rt_vld = 1'b1;
        w_rt     = i[1:0];
      end
    end
  end

  // SCAN choice: keep direction while calls remain ahead, otherwise reverse
  always_comb begin
    w_sel_vld   = 1'b0;
    w_sel_floor = r_target;
    w_sel_dir   = r_dir_up;
    if (r_dir_up) begin
      if (w_above_vld) begin
        w_sel_vld = 1'b1; w_sel_floor = w_above; w_sel_dir = 1'b1;
      end else if (w_below_vld) begin
        w_sel_vld = 1'b1; w_sel_floor = w_below; w_sel_dir = 1'b0;
      end
    end else begin
      if (w_below_vld) begin
        w_sel_vld = 1'b1; w_sel_floor = w_below; w_sel_dir = 1'b0;
      end else if (w_above_vld) begin
        w_sel_vld = 1'b1; w_sel_floor = w_above; w_sel_dir = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (r_pending != 4'b0000) w_state_nxt = S_SELECT;
      S_SELECT: begin
        if (w_here)         w_state_nxt = S_DOOR;
        else if (w_sel_vld) w_state_nxt = S_MOVE;
        else                w_state_nxt = S_IDLE;
      end
      S_MOVE: begin
        if (w_wdog_trip)   w_state_nxt = S_IDLE;
        else if (w_arrive) w_state_nxt = S_DOOR;
      end
      S_DOOR:   if (w_expire) w_state_nxt = (w_pending_nxt != 4'b0000) ? S_SELECT : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and datapath
  always_comb begin
    w_target_nxt  = r_target;
    w_dir_nxt     = r_dir_up;
    w_pending_nxt = r_pending | w_calls;
    w_dwell_nxt   = (r_state != S_DOOR || w_reload) ? DWELL_LOAD : r_dwell - 1'b1;
    case (r_state)
      S_SELECT: begin
        if (w_here) begin
          w_pending_nxt = (r_pending | w_calls) & ~w_floor_oh;
        end else if (w_sel_vld) begin
          w_target_nxt = w_sel_floor;
          w_dir_nxt    = w_sel_dir;
        end
      end
      S_MOVE: begin
        if (w_wdog_trip)                  w_pending_nxt = 4'b0000;
        else if (w_arrive)                w_pending_nxt = (r_pending | w_calls) & ~w_target_oh;
        else if (w_rt_vld && !car_arrived) w_target_nxt = w_rt;
      end
      S_DOOR:   w_pending_nxt = r_pending | (w_calls & ~w_floor_oh);
      default:  ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_target    <= 2'd0;
      r_dir_up    <= 1'b1;
      r_pending   <= 4'b0000;
      r_move_req  <= 1'b0;
      r_door_open <= 1'b0;
      r_dwell     <= DWELL_LOAD;
    end else begin
      r_target    <= w_target_nxt;
      r_dir_up    <= w_dir_nxt;
      r_pending   <= w_pending_nxt;
      r_move_req  <= (w_state_nxt == S_MOVE);
      r_door_open <= (w_state_nxt == S_DOOR);
      r_dwell     <= w_dwell_nxt;
    end
  end

  assign target_floor = r_target;
  assign move_req     = r_move_req;
  assign door_open    = r_door_open;
  assign dir_up       = r_dir_up;
  assign pending      = r_pending;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler (DWELL_CYCLES=8, WDOG_CYCLES=64).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] call_req;
  logic [1:0] car_floor;
  logic       car_arrived;
  logic       sw_open;
  logic       sw_close;
  logic [1:0] target_floor;
  logic       move_req;
  logic       door_open;
  logic       dir_up;
  logic [3:0] pending;
  logic       fault;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cnt;

  localparam logic [7:0] ST_IDLE   = 8'd0;
  localparam logic [7:0] ST_SELECT = 8'd1;

  elevator_call_scheduler #(.DWELL_CYCLES(8), .WDOG_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .call_req(call_req), .car_floor(car_floor),
    .car_arrived(car_arrived), .sw_open(sw_open), .sw_close(sw_close),
    .target_floor(target_floor), .move_req(move_req), .door_open(door_open),
    .dir_up(dir_up), .pending(pending), .fault(fault), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts cycles with door_open high, starting from the current cycle (bounded)
  task automatic count_door(output int n);
    n = 0;
    while (door_open && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; call_req = 4'b0; car_floor = 2'd0; car_arrived = 1'b0;
    sw_open = 1'b0; sw_close = 1'b0;
    tick(); tick();
    chk("rst_target", 8'(target_floor), 8'd0);
    chk("rst_move",   8'(move_req),     8'd0);
    chk("rst_door",   8'(door_open),    8'd0);
    chk("rst_dir",    8'(dir_up),       8'd1);
    chk("rst_pend",   8'(pending),      8'd0);
    chk("rst_fault",  8'(fault),        8'd0);
    reset = 1'b1;
    tick(); tick(); tick();
    chk("idle_stay_state", 8'(dbg_state), ST_IDLE);
    chk("idle_stay_door",  8'(door_open), 8'd0);

    // Floor 0, call floor 3: move at N+3, arrive, dwell 8 cycles
    call_req = 4'b1000; tick(); call_req = 4'b0;
    chk("c3_pend_n1", 8'(pending), 8'h8);
    chk("c3_move_n1", 8'(move_req), 8'd0);
    tick();
    chk("c3_sel_n2", 8'(dbg_state), ST_SELECT);
    chk("c3_move_n2", 8'(move_req), 8'd0);
    tick();
    chk("c3_move_n3", 8'(move_req), 8'd1);
    chk("c3_tgt_n3", 8'(target_floor), 8'd3);
    car_floor = 2'd1; tick();
    chk("c3_moving", 8'(move_req), 8'd1);
    car_floor = 2'd3; car_arrived = 1'b1; tick(); car_arrived = 1'b0;
    chk("c3_arr_move", 8'(move_req), 8'd0);
    chk("c3_arr_door", 8'(door_open), 8'd1);
    chk("c3_arr_pend", 8'(pending), 8'h0);
    count_door(cnt);
    chk("c3_dwell_len", 8'(cnt), 8'd8);
    chk("c3_end_idle", 8'(dbg_state), ST_IDLE);

    // SCAN: at floor 1 going up with calls at 0 and 3 -> 3 first, then 0
    car_floor = 2'd1; call_req = 4'b1001; tick(); call_req = 4'b0;
    tick(); tick();
    chk("scan_tgt3", 8'(target_floor), 8'd3);
    chk("scan_dir_up", 8'(dir_up), 8'd1);
    car_floor = 2'd3; car_arrived = 1'b1; tick(); car_arrived = 1'b0;
    chk("scan_door3", 8'(door_open), 8'd1);
    chk("scan_pend3", 8'(pending), 8'h1);
    sw_close = 1'b1; tick(); sw_close = 1'b0;
    chk("scan_close_door", 8'(door_open), 8'd0);
    chk("scan_reselect", 8'(dbg_state), ST_SELECT);
    tick();
    chk("scan_dir_down", 8'(dir_up), 8'd0);
    chk("scan_tgt0", 8'(target_floor), 8'd0);
    chk("scan_move0", 8'(move_req), 8'd1);
    car_floor = 2'd0; car_arrived = 1'b1; tick(); car_arrived = 1'b0;
    chk("scan_door0", 8'(door_open), 8'd1);
    chk("scan_pend0", 8'(pending), 8'h0);

    // Door held open by sw_open for 20 cycles, then full dwell
    sw_open = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_door", 8'(door_open), 8'd1);
    end
    sw_open = 1'b0;
    count_door(cnt);
    chk("hold_dwell_after", 8'(cnt), 8'd8);

    // Call at current floor while idle: door at N+3, no move; then sw_open/sw_close
    call_req = 4'b0001; tick(); call_req = 4'b0;
    tick(); tick();
    chk("here_door", 8'(door_open), 8'd1);
    chk("here_nomove", 8'(move_req), 8'd0);
    chk("here_pend", 8'(pending), 8'h0);
    tick();
    sw_open = 1'b1; sw_close = 1'b1; tick(); sw_open = 1'b0; sw_close = 1'b0;
    chk("both_open_wins", 8'(door_open), 8'd1);
    tick();
    sw_close = 1'b1; tick(); sw_close = 1'b0;
    chk("close_k2_door", 8'(door_open), 8'd0);
    chk("close_k2_idle", 8'(dbg_state), ST_IDLE);

    // Retarget: 0->3, call 2 while at floor 1; wrong-floor arrival ignored
    call_req = 4'b1000; tick(); call_req = 4'b0;
    tick(); tick();
    chk("rt_dir_flip", 8'(dir_up), 8'd1);
    chk("rt_tgt3", 8'(target_floor), 8'd3);
    car_floor = 2'd1; call_req = 4'b0100; tick(); call_req = 4'b0;
    chk("rt_tgt2", 8'(target_floor), 8'd2);
    chk("rt_pend", 8'(pending), 8'hC);
    car_floor = 2'd3; car_arrived = 1'b1; tick(); car_arrived = 1'b0;
    chk("rt_ign_move", 8'(move_req), 8'd1);
    chk("rt_ign_door", 8'(door_open), 8'd0);
    chk("rt_ign_tgt", 8'(target_floor), 8'd2);
    car_floor = 2'd2; car_arrived = 1'b1; tick(); car_arrived = 1'b0;
    chk("rt_door2", 8'(door_open), 8'd1);
    chk("rt_pend2", 8'(pending), 8'h8);
    sw_close = 1'b1; tick(); sw_close = 1'b0;
    chk("rt_resel", 8'(dbg_state), ST_SELECT);
    tick();
    chk("rt_tgt3b", 8'(target_floor), 8'd3);
    chk("rt_move3b", 8'(move_req), 8'd1);
    car_floor = 2'd3; car_arrived = 1'b1; tick(); car_arrived = 1'b0;
    chk("rt_door3", 8'(door_open), 8'd1);

    // Asynchronous reset mid-DOOR
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_door", 8'(door_open), 8'd0);
    chk("mid_rst_tgt", 8'(target_floor), 8'd0);
    chk("mid_rst_dir", 8'(dir_up), 8'd1);
    chk("mid_rst_state", 8'(dbg_state), ST_IDLE);
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_idle", 8'(dbg_state), ST_IDLE);
    chk("post_rst_door", 8'(door_open), 8'd0);

`ifdef ELEV_SCHED_WDOG_EN
    // Watchdog: no arrival for 64 MOVE cycles -> sticky fault
    car_floor = 2'd0; call_req = 4'b1000; tick(); call_req = 4'b0;
    tick(); tick();
    chk("wd_move", 8'(move_req), 8'd1);
    repeat (63) tick();
    chk("wd_before_fault", 8'(fault), 8'd0);
    chk("wd_before_move", 8'(move_req), 8'd1);
    tick();
    chk("wd_fault", 8'(fault), 8'd1);
    chk("wd_move_off", 8'(move_req), 8'd0);
    chk("wd_pend_clr", 8'(pending), 8'h0);
    chk("wd_idle", 8'(dbg_state), ST_IDLE);
    call_req = 4'b0010; tick(); call_req = 4'b0;
    tick(); tick();
    chk("wd_call_ign", 8'(pending), 8'h0);
    chk("wd_no_move", 8'(move_req), 8'd0);
    chk("wd_sticky", 8'(fault), 8'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
